// File: rtl/frame3_pkg.sv
// Shared types, constants and the symbol-select helper for the 3-symbol frame
// serializer.
package frame3_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int PHASE_W = 2;
   localparam logic [PHASE_W-1:0] PHASE_LAST = 2'd2;

   // Widest symbol the select helper handles; callers zero-extend their frame.
   localparam int SYM_MAX = 64;

   // Symbol k of a frame of w-bit symbols; the caller truncates to its own width.
   function automatic logic [SYM_MAX-1:0] frame3_sym(
      input logic [3*SYM_MAX-1:0] frame,
      input int unsigned          w,
      input logic [PHASE_W-1:0]   k
   );
      logic [3*SYM_MAX-1:0] sh;
      sh = frame >> (32'(k) * w);
      return sh[SYM_MAX-1:0];
   endfunction

endpackage

// File: rtl/frame3_serializer_phase_ctr3.sv
// Mod-3 phase counter: 0 -> 1 -> 2 -> 0. Clr forces phase 0 and wins over En.
module phase_ctr3
   import frame3_pkg::*;
(
   input  logic               Clk,
   input  logic               Reset,
   input  logic               En,
   input  logic               Clr,
   output logic [PHASE_W-1:0] Phase,
   output logic               Last
);

   // Advance on En, wrapping after phase 2 so the value 3 never occurs.
   always_ff @(posedge Clk) begin
      if (Reset || Clr)
         Phase <= '0;
      else if (En)
         Phase <= Last ? '0 : Phase + 2'd1;
   end

   assign Last = (Phase == PHASE_LAST);

endmodule

// File: rtl/frame3_serializer.sv
// Accepts one 3-symbol frame over valid/ready and emits it one W-bit symbol per
// phase (0,1,2). InReady is combinational on OutReady at phase 2 so frames can
// run back-to-back without a bubble.
// Optional feature: define FRAME3_PARITY_EN to add OutPar = ^OutSym.
module frame3_serializer
   import frame3_pkg::*;
#(
   parameter int W = 8
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic [3*W-1:0] InData,
   input  logic           InValid,
   output logic           InReady,
   output logic [W-1:0]   OutSym,
   output logic [1:0]     OutPhase,
   output logic           OutValid,
   input  logic           OutReady,
   output logic           FrameDone
`ifdef FRAME3_PARITY_EN
   ,
   output logic           OutPar
`endif
);

   state_t             state;
   logic [3*W-1:0]     frame_q;
   logic [PHASE_W-1:0] phase;
   logic               last;
   logic               in_acc;
   logic               out_acc;
   logic               load_sym;
   logic               take_new;
   logic [PHASE_W-1:0] next_k;
   logic [3*W-1:0]     frame_src;
   logic [W-1:0]       next_sym;

   assign InReady  = (state == IDLE) || (last && OutReady);
   assign in_acc   = InValid && InReady;
   assign out_acc  = OutValid && OutReady;
   assign load_sym = (state == IDLE) ? in_acc : out_acc;
   assign OutPhase = phase;

   phase_ctr3 u_phase (
      .Clk   (Clk),
      .Reset (Reset),
      .En    (out_acc),
      .Clr   (in_acc),
      .Phase (phase),
      .Last  (last)
   );

   // Pick the symbol shown next: symbol 0 of the incoming frame when a new
   // frame is being taken, otherwise the following symbol of the held frame.
   always_comb begin
      take_new  = (state == IDLE) || last;
      frame_src = take_new ? InData : frame_q;
      next_k    = take_new ? '0 : phase + 2'd1;
      next_sym  = W'(frame3_sym((3*SYM_MAX)'(frame_src), W, next_k));
   end

   // Control FSM with frame register and registered symbol outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         OutValid  <= 1'b0;
         OutSym    <= '0;
         FrameDone <= 1'b0;
      end else begin
         FrameDone <= 1'b0;
         if (load_sym)
            OutSym <= next_sym;
         case (state)
            IDLE: begin
               if (in_acc) begin
                  frame_q  <= InData;
                  OutValid <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (out_acc && last) begin
                  FrameDone <= 1'b1;
                  if (in_acc) begin
                     frame_q <= InData;
                  end else begin
                     OutValid <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef FRAME3_PARITY_EN
   // Parity register tracks OutSym load-for-load.
   always_ff @(posedge Clk) begin
      if (Reset)
         OutPar <= 1'b0;
      else if (load_sym)
         OutPar <= ^next_sym;
   end
`endif

endmodule

// File: tb/tb_frame3_serializer.sv
// Directed bench for frame3_serializer (W=8).
module tb_frame3_serializer;

   logic        Clk;
   logic        Reset;
   logic [23:0] InData;
   logic        InValid;
   logic        InReady;
   logic [7:0]  OutSym;
   logic [1:0]  OutPhase;
   logic        OutValid;
   logic        OutReady;
   logic        FrameDone;
`ifdef FRAME3_PARITY_EN
   logic        OutPar;
`endif

   int tests;
   int fails;

   frame3_serializer #(.W(8)) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .InData    (InData),
      .InValid   (InValid),
      .InReady   (InReady),
      .OutSym    (OutSym),
      .OutPhase  (OutPhase),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .FrameDone (FrameDone)
`ifdef FRAME3_PARITY_EN
      ,
      .OutPar    (OutPar)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset    = 1'b1;
      InValid  = 1'b0;
      InData   = 24'h0;
      OutReady = 1'b1;
      step();
      step();
      tests++;
      if (OutValid !== 1'b0) begin fails++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
      tests++;
      if (OutPhase !== 2'd0) begin fails++; $display("FAIL reset_phase got=%0d exp=0", OutPhase); end
      tests++;
      if (FrameDone !== 1'b0) begin fails++; $display("FAIL reset_framedone got=%b exp=0", FrameDone); end
      tests++;
      if (OutSym !== 8'h00) begin fails++; $display("FAIL reset_outsym got=%h exp=00", OutSym); end
      tests++;
      if (InReady !== 1'b1) begin fails++; $display("FAIL reset_inready got=%b exp=1", InReady); end
      Reset = 1'b0;
      step();
      tests++;
      if (InReady !== 1'b1) begin fails++; $display("FAIL idle_inready got=%b exp=1", InReady); end
   endtask

   task automatic test_single();
      logic [7:0] exp_sym [3];
      exp_sym[0] = 8'h11; exp_sym[1] = 8'h22; exp_sym[2] = 8'h33;
      InData  = 24'h332211;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (OutValid !== 1'b1 || OutSym !== exp_sym[i] || OutPhase !== 2'(i))
            begin fails++; $display("FAIL single_sym%0d got v=%b s=%h p=%0d exp v=1 s=%h p=%0d", i, OutValid, OutSym, OutPhase, exp_sym[i], i); end
         tests++;
         if (InReady !== (i == 2)) begin fails++; $display("FAIL single_inready%0d got=%b exp=%b", i, InReady, (i == 2)); end
         tests++;
         if (FrameDone !== 1'b0) begin fails++; $display("FAIL single_fd_early%0d got=%b exp=0", i, FrameDone); end
         step();
      end
      tests++;
      if (FrameDone !== 1'b1 || OutValid !== 1'b0) begin fails++; $display("FAIL single_done got fd=%b v=%b exp fd=1 v=0", FrameDone, OutValid); end
      step();
      tests++;
      if (FrameDone !== 1'b0 || InReady !== 1'b1) begin fails++; $display("FAIL single_idle got fd=%b rdy=%b exp fd=0 rdy=1", FrameDone, InReady); end
   endtask

   task automatic test_back_to_back();
      InData  = 24'h030201;
      InValid = 1'b1;
      step();
      InData = 24'h060504;
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (OutValid !== 1'b1 || OutSym !== 8'(i + 1) || OutPhase !== 2'(i % 3))
            begin fails++; $display("FAIL b2b_sym%0d got v=%b s=%h p=%0d exp v=1 s=%h p=%0d", i, OutValid, OutSym, OutPhase, 8'(i + 1), i % 3); end
         tests++;
         if (InReady !== (i % 3 == 2)) begin fails++; $display("FAIL b2b_inready%0d got=%b exp=%b", i, InReady, (i % 3 == 2)); end
         tests++;
         if (FrameDone !== (i == 3)) begin fails++; $display("FAIL b2b_fd%0d got=%b exp=%b", i, FrameDone, (i == 3)); end
         if (i == 5) InValid = 1'b0;
         step();
      end
      tests++;
      if (FrameDone !== 1'b1 || OutValid !== 1'b0) begin fails++; $display("FAIL b2b_end got fd=%b v=%b exp fd=1 v=0", FrameDone, OutValid); end
      step();
   endtask

   task automatic test_stall();
      InData  = 24'h332211;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      step();
      OutReady = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         tests++;
         if (OutValid !== 1'b1 || OutSym !== 8'h22 || OutPhase !== 2'd1)
            begin fails++; $display("FAIL stall_hold%0d got v=%b s=%h p=%0d exp v=1 s=22 p=1", i, OutValid, OutSym, OutPhase); end
         tests++;
         if (InReady !== 1'b0) begin fails++; $display("FAIL stall_inready%0d got=%b exp=0", i, InReady); end
      end
      OutReady = 1'b1;
      step();
      tests++;
      if (OutSym !== 8'h33 || OutPhase !== 2'd2) begin fails++; $display("FAIL stall_resume got s=%h p=%0d exp s=33 p=2", OutSym, OutPhase); end
      step();
      tests++;
      if (FrameDone !== 1'b1) begin fails++; $display("FAIL stall_done got=%b exp=1", FrameDone); end
      step();
   endtask

   task automatic test_reset_mid();
      InData  = 24'h332211;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      step();
      tests++;
      if (OutPhase !== 2'd1) begin fails++; $display("FAIL rmid_pre got p=%0d exp=1", OutPhase); end
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      tests++;
      if (OutValid !== 1'b0 || FrameDone !== 1'b0 || OutPhase !== 2'd0)
         begin fails++; $display("FAIL rmid_after got v=%b fd=%b p=%0d exp v=0 fd=0 p=0", OutValid, FrameDone, OutPhase); end
      step();
      tests++;
      if (FrameDone !== 1'b0 || InReady !== 1'b1) begin fails++; $display("FAIL rmid_idle got fd=%b rdy=%b exp fd=0 rdy=1", FrameDone, InReady); end
      InData  = 24'hCCBBAA;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      tests++;
      if (OutValid !== 1'b1 || OutSym !== 8'hAA || OutPhase !== 2'd0)
         begin fails++; $display("FAIL rmid_next got v=%b s=%h p=%0d exp v=1 s=aa p=0", OutValid, OutSym, OutPhase); end
      step();
      step();
      tests++;
      if (OutSym !== 8'hCC || OutPhase !== 2'd2) begin fails++; $display("FAIL rmid_last got s=%h p=%0d exp s=cc p=2", OutSym, OutPhase); end
      step();
      tests++;
      if (FrameDone !== 1'b1) begin fails++; $display("FAIL rmid_done got=%b exp=1", FrameDone); end
      step();
   endtask

`ifdef FRAME3_PARITY_EN
   task automatic test_parity();
      InData  = 24'h000307;
      InValid = 1'b1;
      step();
      InValid = 1'b0;
      tests++;
      if (OutSym !== 8'h07 || OutPar !== 1'b1) begin fails++; $display("FAIL par_07 got s=%h par=%b exp s=07 par=1", OutSym, OutPar); end
      step();
      tests++;
      if (OutSym !== 8'h03 || OutPar !== 1'b0) begin fails++; $display("FAIL par_03 got s=%h par=%b exp s=03 par=0", OutSym, OutPar); end
      step();
      step();
   endtask
`endif

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_reset_mid();
`ifdef FRAME3_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
